// File: rtl/ov7670_pkg.sv
// Shared OV7670 camera-bus definitions for the synthesizable source and the capture block.
package ov7670_pkg;

  localparam int OV_H_ACTIVE  = 640;
  localparam int OV_V_ACTIVE  = 480;
  localparam int OV_H_BLANK   = 10;
  localparam int OV_VSYNC_LEN = 4;
  localparam int OV_V_BACK    = 2;

  typedef enum logic [2:0] {
    SRC_IDLE   = 3'd0,
    SRC_VSYNC  = 3'd1,
    SRC_VBACK  = 3'd2,
    SRC_ACTIVE = 3'd3,
    SRC_HBLANK = 3'd4
  } src_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Camera byte order is MSB first: lsb=0 selects [15:8], lsb=1 selects [7:0].
  function automatic logic [7:0] rgb565_byte(input rgb565_t px, input logic lsb);
    logic [15:0] raw;
    raw = px;
    if (lsb) begin
      return raw[7:0];
    end else begin
      return raw[15:8];
    end
  endfunction

endpackage

// File: rtl/ov7670_source.sv
// OV7670 camera-side transmitter: replays an RGB565 stream as pclk/vsync/href/data.
// pclk is clk/2; every bus change happens on the clk edge where pclk falls.
module ov7670_source
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE  = OV_H_ACTIVE,
  parameter int V_ACTIVE  = OV_V_ACTIVE,
  parameter int H_BLANK   = OV_H_BLANK,
  parameter int VSYNC_LEN = OV_VSYNC_LEN,
  parameter int V_BACK    = OV_V_BACK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic        underflow
);

  localparam int BMAX_A = (H_BLANK > VSYNC_LEN) ? H_BLANK : VSYNC_LEN;
  localparam int BMAX   = (BMAX_A > V_BACK) ? BMAX_A : V_BACK;
  localparam int CW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BW     = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] COL_LAST    = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] VSYNC_LAST  = BW'(VSYNC_LEN - 1);
  localparam logic [BW-1:0] VBACK_LAST  = BW'(V_BACK - 1);
  localparam logic [BW-1:0] HBLANK_LAST = BW'(H_BLANK - 1);

  logic          ph_r;
  src_state_t    state_r, state_n;
  logic [BW-1:0] cnt_r, cnt_n;
  logic [CW-1:0] col_r, col_n;
  logic [RW-1:0] row_r, row_n;
  logic          lsb_r, lsb_n;
  rgb565_t       hold_r, hold_n;
  logic          vsync_r, vsync_n;
  logic          href_r, href_n;
  logic [7:0]    data_r, data_n;
  logic          ready_r, ready_n;
  logic          done_r, done_n;
  logic          uf_r, uf_n;

  // Phase, FSM state, counters and all registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_r    <= 1'b0;
      state_r <= SRC_IDLE;
      cnt_r   <= '0;
      col_r   <= '0;
      row_r   <= '0;
      lsb_r   <= 1'b0;
      hold_r  <= '0;
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
      data_r  <= 8'h00;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      uf_r    <= 1'b0;
    end else begin
      ph_r    <= ~ph_r;
      state_r <= state_n;
      cnt_r   <= cnt_n;
      col_r   <= col_n;
      row_r   <= row_n;
      lsb_r   <= lsb_n;
      hold_r  <= hold_n;
      vsync_r <= vsync_n;
      href_r  <= href_n;
      data_r  <= data_n;
      ready_r <= ready_n;
      done_r  <= done_n;
      uf_r    <= uf_n;
    end
  end

  // Next state and outputs; state advances only on launch edges (ph_r=1).
  // The state names the segment the coming launch edge drives onto the bus.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    col_n   = col_r;
    row_n   = row_r;
    lsb_n   = lsb_r;
    hold_n  = hold_r;
    vsync_n = vsync_r;
    href_n  = href_r;
    data_n  = data_r;
    ready_n = 1'b0;
    done_n  = 1'b0;
    uf_n    = 1'b0;
    if (!ph_r) begin
      // The cycle after this edge ends in an MSB launch: offer the pixel slot.
      ready_n = (state_r == SRC_ACTIVE) && !lsb_r;
    end else begin
      vsync_n = 1'b0;
      href_n  = 1'b0;
      data_n  = 8'h00;
      case (state_r)
        SRC_IDLE: begin
          if (start) begin
            state_n = SRC_VSYNC;
            cnt_n   = '0;
          end else begin
            state_n = SRC_IDLE;
          end
        end
        SRC_VSYNC: begin
          vsync_n = 1'b1;
          if (cnt_r == VSYNC_LAST) begin
            state_n = SRC_VBACK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + BW'(1);
          end
        end
        SRC_VBACK: begin
          if (cnt_r == VBACK_LAST) begin
            state_n = SRC_ACTIVE;
            cnt_n   = '0;
            col_n   = '0;
            row_n   = '0;
            lsb_n   = 1'b0;
          end else begin
            cnt_n = cnt_r + BW'(1);
          end
        end
        SRC_ACTIVE: begin
          href_n = 1'b1;
          if (!lsb_r) begin
            // A missing pixel is sent as black; line timing never stalls.
            if (pix_valid) begin
              hold_n = rgb565_t'(pix_data);
            end else begin
              hold_n = '0;
              uf_n   = 1'b1;
            end
            data_n = rgb565_byte(hold_n, 1'b0);
            lsb_n  = 1'b1;
          end else begin
            data_n = rgb565_byte(hold_r, 1'b1);
            lsb_n  = 1'b0;
            if (col_r == COL_LAST) begin
              state_n = SRC_HBLANK;
              col_n   = '0;
              cnt_n   = '0;
            end else begin
              col_n = col_r + CW'(1);
            end
          end
        end
        SRC_HBLANK: begin
          if (cnt_r == HBLANK_LAST) begin
            cnt_n = '0;
            if (row_r != ROW_LAST) begin
              row_n   = row_r + RW'(1);
              state_n = SRC_ACTIVE;
            end else begin
              row_n   = '0;
              done_n  = 1'b1;
              state_n = start ? SRC_VSYNC : SRC_IDLE;
            end
          end else begin
            cnt_n = cnt_r + BW'(1);
          end
        end
        default: begin
          state_n = SRC_IDLE;
          cnt_n   = '0;
          col_n   = '0;
          row_n   = '0;
          lsb_n   = 1'b0;
        end
      endcase
    end
  end

  assign pclk       = ph_r;
  assign vsync      = vsync_r;
  assign href       = href_r;
  assign data       = data_r;
  assign pix_ready  = ready_r;
  assign frame_done = done_r;
  assign underflow  = uf_r;

endmodule

// File: tb/tb_ov7670_source.sv
// Directed bench for ov7670_source with a 4x3 image: frame timing, byte order,
// underflow, back-to-back frames, return to idle and asynchronous reset mid-line.
module tb_ov7670_source;

  localparam int HA      = 4;
  localparam int VA      = 3;
  localparam int HB      = 10;
  localparam int VS      = 4;
  localparam int VB      = 2;
  localparam int LINE_L  = 2 * HA + HB;
  localparam int FRAME_L = VS + VB + VA * LINE_L;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pclk;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        frame_done;
  logic        underflow;

  int          n_checks;
  int          n_pass;
  int          ready_seen;
  logic [15:0] next_pix;
  logic [15:0] exp_next;
  logic [9:0]  exp_prev;

  ov7670_source #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pclk       (pclk),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One pclk period ending in a launch edge; bus is {vsync, href, data}.
  task automatic launch(input logic valid_i, input logic exp_rdy, input logic [9:0] exp_bus,
                        input logic exp_fd, input logic exp_uf);
    logic rdy;
    pix_valid = valid_i;
    @(posedge clk); #1;
    check("pclk_rise", 32'(pclk), 32'd1);
    check("bus_on_rise", 32'(({vsync, href, data})), 32'(exp_prev));
    check("pulse_width", 32'(({frame_done, underflow})), 32'd0);
    check("ready", 32'(pix_ready), 32'(exp_rdy));
    rdy = pix_ready;
    @(posedge clk); #1;
    check("pclk_fall", 32'(pclk), 32'd0);
    check("bus", 32'(({vsync, href, data})), 32'(exp_bus));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("underflow", 32'(underflow), 32'(exp_uf));
    check("ready_off", 32'(pix_ready), 32'd0);
    if (rdy) begin
      ready_seen++;
      if (valid_i) begin
        next_pix++;
        pix_data = next_pix;
      end
    end
    exp_prev = exp_bus;
  endtask

  // Walks n_launch launch edges of a frame that starts with its first vsync launch.
  task automatic run_frame(input int n_launch, input int drop_slot, input logic last_start);
    logic [15:0] hold;
    logic [9:0]  exp_bus;
    logic        exp_rdy;
    logic        exp_uf;
    logic        valid;
    int          g;
    int          line;
    int          pos;
    int          slot;
    hold = 16'h0000;
    for (int f = 0; f < n_launch; f++) begin
      exp_bus = 10'h000;
      exp_rdy = 1'b0;
      exp_uf  = 1'b0;
      valid   = 1'b1;
      if (f < VS) begin
        exp_bus = {1'b1, 1'b0, 8'h00};
      end else if (f >= VS + VB) begin
        g    = f - VS - VB;
        line = g / LINE_L;
        pos  = g % LINE_L;
        if (pos < 2 * HA) begin
          if (pos % 2 == 0) begin
            slot    = line * HA + pos / 2;
            exp_rdy = 1'b1;
            if (slot == drop_slot) begin
              valid  = 1'b0;
              hold   = 16'h0000;
              exp_uf = 1'b1;
            end else begin
              hold = exp_next;
              exp_next++;
            end
            exp_bus = {1'b0, 1'b1, hold[15:8]};
          end else begin
            exp_bus = {1'b0, 1'b1, hold[7:0]};
          end
        end
      end
      if (f == FRAME_L - 1) begin
        start = last_start;
      end
      launch(valid, exp_rdy, exp_bus, (f == FRAME_L - 1), exp_uf);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    ready_seen = 0;
    next_pix   = 16'h0000;
    exp_next   = 16'h0000;
    exp_prev   = 10'h000;
    rst        = 1'b0;
    start      = 1'b0;
    pix_valid  = 1'b1;
    pix_data   = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'(({pclk, vsync, href, data, pix_ready, frame_done, underflow})), 32'd0);

    // Frame 1: start held high, ramp pixels 0..11, back-to-back into frame 2.
    start = 1'b1;
    rst   = 1'b1;
    launch(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
    ready_seen = 0;
    run_frame(FRAME_L, -1, 1'b1);
    check("ready_count_f1", 32'(ready_seen), 32'(HA * VA));

    // Frame 2: vsync on the launch right after frame_done; one missing pixel at col 2.
    ready_seen = 0;
    run_frame(FRAME_L, 2, 1'b0);
    check("ready_count_f2", 32'(ready_seen), 32'(HA * VA));
    check("stream_pos_f2", 32'(next_pix), 32'd23);

    // start low at end of frame: bus idles.
    for (int i = 0; i < 3; i++) begin
      launch(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
    end

    // Frame 3: abort with an asynchronous reset in row 1, col 2.
    start = 1'b1;
    launch(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
    run_frame(VS + VB + LINE_L + 4, -1, 1'b1);
    @(posedge clk); #3;
    check("mid_line_href", 32'(href), 32'd1);
    rst = 1'b0;
    #1;
    check("async_reset_outputs",
          32'(({pclk, vsync, href, data, pix_ready, frame_done, underflow})), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst      = 1'b1;
    exp_prev = 10'h000;

    // Frame 4: restarts at vsync and continues the upstream stream at pixel 29.
    check("stream_pos_f3", 32'(next_pix), 32'd29);
    launch(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
    ready_seen = 0;
    run_frame(FRAME_L, -1, 1'b0);
    check("ready_count_f4", 32'(ready_seen), 32'(HA * VA));
    launch(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
